// File: rtl/sha_multi_lane_pad_hash.sv
// sha_multi_lane_pad_hash
//   Pads LANES independent SHA-2 hash states (words a..h) into 512-bit
//   message blocks that carry the digest as the next message. Beats pass
//   through a two-entry skid buffer so ready_o is a pure register decode.
//   Data is stored raw; padding is applied combinationally on the head entry.
//
// Parameters
//   LANES        : independent lanes padded in lockstep (1..8)
//   DIGEST_WORDS : digest words per lane (8 = SHA-256, 7 = SHA-224)
//   WRAPPED      : 1 = wrapped pipeline word order, 0 = canonical FIPS order
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   state_i      : lane k word j (a=0..h=7) at bits [(k*8+j)*32 +: 32]
//   valid_i      : input beat valid
//   newblock_i   : sideband tag travelling with the beat
//   ready_o      : buffer can take a beat (registered, independent of ready_i)
//   padded_o     : lane k block word j at bits [(k*16+j)*32 +: 32], word 0 first
//   valid_o      : padded_o/newblock_o valid
//   newblock_o   : tag of the presented beat
//   ready_i      : downstream accepts the presented beat
//   count_o      : completed output handshakes, modulo 2^16
module sha_multi_lane_pad_hash #(
    parameter int LANES        = 1,
    parameter int DIGEST_WORDS = 8,
    parameter int WRAPPED      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*8*32-1:0]   state_i,
    input  logic                    valid_i,
    input  logic                    newblock_i,
    output logic                    ready_o,
    output logic [LANES*16*32-1:0]  padded_o,
    output logic                    valid_o,
    output logic                    newblock_o,
    input  logic                    ready_i,
    output logic [15:0]             count_o
);

    localparam logic [31:0] LEN_WORD = 32'(DIGEST_WORDS * 32);
    localparam logic [31:0] PAD_MARK = 32'h8000_0000;
    localparam int          SW       = LANES * 8 * 32;

    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("LANES must be in 1..8");
    end
    if (DIGEST_WORDS < 1 || DIGEST_WORDS > 8) begin : g_bad_words
        $error("DIGEST_WORDS must be in 1..8");
    end
    if (WRAPPED != 0 && DIGEST_WORDS != 8) begin : g_bad_wrap
        $error("wrapped layout requires DIGEST_WORDS = 8");
    end

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    buf_state_t    state_q, state_d;
    logic [SW-1:0] slot0_state, slot1_state;
    logic          slot0_nb, slot1_nb;
    logic          push, pop;

    // Builds one lane's 512-bit block from its eight state words.
    function automatic logic [511:0] pad_lane(input logic [255:0] st);
        logic [511:0] blk;
        blk = '0;
        if (WRAPPED != 0) begin
            blk[0*32 +: 32] = st[0 +: 32];
            blk[1*32 +: 32] = LEN_WORD;
            blk[8*32 +: 32] = PAD_MARK;
            // words 9..15 carry h,g,f,e,d,c,b (reverse order)
            for (int i = 9; i < 16; i++) begin
                blk[i*32 +: 32] = st[(16-i)*32 +: 32];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i < DIGEST_WORDS) blk[i*32 +: 32] = st[i*32 +: 32];
            end
            blk[DIGEST_WORDS*32 +: 32] = PAD_MARK;
            blk[15*32 +: 32]           = LEN_WORD;
        end
        return blk;
    endfunction

    assign valid_o = (state_q != EMPTY);
    // Decoded straight from the state register, so never a path from ready_i.
    assign ready_o = (state_q != TWO);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Slot 0 is always the head. Data carries no reset; outputs are gated
    // by valid_o so stale contents are never visible.
    always_ff @(posedge clk) begin
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    slot0_state <= state_i;
                    slot0_nb    <= newblock_i;
                end
            end
            ONE: begin
                if (push && pop) begin
                    slot0_state <= state_i;
                    slot0_nb    <= newblock_i;
                end else if (push) begin
                    slot1_state <= state_i;
                    slot1_nb    <= newblock_i;
                end
            end
            TWO: begin
                if (pop) begin
                    slot0_state <= slot1_state;
                    slot0_nb    <= slot1_nb;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      count_o <= '0;
        else if (pop) count_o <= count_o + 16'd1;
    end

    always_comb begin
        padded_o   = '0;
        newblock_o = 1'b0;
        if (valid_o) begin
            newblock_o = slot0_nb;
            for (int k = 0; k < LANES; k++) begin
                padded_o[k*512 +: 512] = pad_lane(slot0_state[k*256 +: 256]);
            end
        end
    end

endmodule

// File: tb/tb_sha_multi_lane_pad_hash.sv
module tb_sha_multi_lane_pad_hash;

    logic           clk = 1'b0;
    logic           rst;

    // Instance A: two lanes, wrapped layout, SHA-256
    logic [511:0]   a_state;
    logic           a_valid, a_nb, a_ready_o, a_valid_o, a_nb_o, a_ready_i;
    logic [1023:0]  a_padded;
    logic [15:0]    a_count;

    // Instance B: one lane, canonical layout, SHA-224
    logic [255:0]   b_state;
    logic           b_valid, b_nb, b_ready_o, b_valid_o, b_nb_o, b_ready_i;
    logic [511:0]   b_padded;
    logic [15:0]    b_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] wv [16];

    sha_multi_lane_pad_hash #(.LANES(2), .DIGEST_WORDS(8), .WRAPPED(1)) dut_a (
        .clk(clk), .rst(rst), .state_i(a_state), .valid_i(a_valid),
        .newblock_i(a_nb), .ready_o(a_ready_o), .padded_o(a_padded),
        .valid_o(a_valid_o), .newblock_o(a_nb_o), .ready_i(a_ready_i),
        .count_o(a_count)
    );

    sha_multi_lane_pad_hash #(.LANES(1), .DIGEST_WORDS(7), .WRAPPED(0)) dut_b (
        .clk(clk), .rst(rst), .state_i(b_state), .valid_i(b_valid),
        .newblock_i(b_nb), .ready_o(b_ready_o), .padded_o(b_padded),
        .valid_o(b_valid_o), .newblock_o(b_nb_o), .ready_i(b_ready_i),
        .count_o(b_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] blk(input logic [31:0] w [16]);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = w[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 word a = v, lane 1 word a = v+1, all other words zero.
    task automatic set_beat(input logic [31:0] v, input logic nb);
        a_state            = '0;
        a_state[31:0]      = v;
        a_state[8*32 +: 32] = v + 32'd1;
        a_nb               = nb;
        a_valid            = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        a_state = '0; a_valid = 0; a_nb = 0; a_ready_i = 1;
        b_state = '0; b_valid = 0; b_nb = 0; b_ready_i = 1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 512'(a_valid_o), 512'd0);
        check("rst_ready", 512'(a_ready_o), 512'd1);
        check("rst_count", 512'(a_count), 512'd0);
        check("rst_nb", 512'(a_nb_o), 512'd0);
        check("rst_pad0", a_padded[511:0], 512'd0);
        check("rst_pad1", a_padded[1023:512], 512'd0);
        check("rst_b_valid", 512'(b_valid_o), 512'd0);

        // First beat on the first edge after release; both layouts
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            a_state[j*32 +: 32]     = 32'(j + 1);
            a_state[(8+j)*32 +: 32] = 32'h11 * 32'(j + 1);
        end
        for (int j = 0; j < 7; j++) b_state[j*32 +: 32] = 32'(j + 1);
        b_state[7*32 +: 32] = 32'hFFFF_FFFF;
        a_valid = 1; a_nb = 1; b_valid = 1; b_nb = 0;
        step();
        a_valid = 0; b_valid = 0;
        check("w_valid", 512'(a_valid_o), 512'd1);
        check("w_nb", 512'(a_nb_o), 512'd1);
        wv = '{32'd1, 32'd256, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
               32'h8000_0000, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2};
        check("w_lane0", a_padded[511:0], blk(wv));
        wv = '{32'h11, 32'd256, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
               32'h8000_0000, 32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22};
        check("w_lane1", a_padded[1023:512], blk(wv));
        wv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'h8000_0000,
               32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd224};
        check("c224_block", b_padded, blk(wv));
        check("c224_valid", 512'(b_valid_o), 512'd1);
        step();
        check("w_count", 512'(a_count), 512'd1);
        check("w_drain", 512'(a_valid_o), 512'd0);
        check("c224_count", 512'(b_count), 512'd1);

        // Back-pressure: three back-to-back beats with ready_i low
        a_ready_i = 0;
        set_beat(32'hB000, 1'b0);
        step();
        check("bp_ready1", 512'(a_ready_o), 512'd1);
        check("bp_head0", 512'(a_padded[31:0]), 512'h0000B000);
        set_beat(32'hB001, 1'b1);
        step();
        check("bp_ready2", 512'(a_ready_o), 512'd0);
        check("bp_nb0", 512'(a_nb_o), 512'd0);
        set_beat(32'hB002, 1'b0);
        step();
        check("bp_held", 512'(a_ready_o), 512'd0);
        check("bp_stable0", 512'(a_padded[31:0]), 512'h0000B000);
        check("bp_stable1", 512'(a_padded[543:512]), 512'h0000B001);
        a_ready_i = 1;
        step();
        check("bp_out1", 512'(a_padded[31:0]), 512'h0000B001);
        check("bp_out1_nb", 512'(a_nb_o), 512'd1);
        check("bp_ready3", 512'(a_ready_o), 512'd1);
        step();
        a_valid = 0;
        check("bp_out2", 512'(a_padded[31:0]), 512'h0000B002);
        check("bp_out2_vld", 512'(a_valid_o), 512'd1);
        step();
        check("bp_empty", 512'(a_valid_o), 512'd0);
        check("bp_count", 512'(a_count), 512'd4);

        // Asynchronous reset with the buffer full
        a_ready_i = 0;
        set_beat(32'hC000, 1'b1);
        step();
        set_beat(32'hC001, 1'b1);
        step();
        a_valid = 0;
        check("ar_full", 512'(a_ready_o), 512'd0);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 512'(a_valid_o), 512'd0);
        check("ar_count", 512'(a_count), 512'd0);
        check("ar_ready", 512'(a_ready_o), 512'd1);
        check("ar_pad", a_padded[511:0], 512'd0);
        step();
        rst = 1'b0;
        a_ready_i = 1;
        step();
        check("ar_nostale1", 512'(a_valid_o), 512'd0);
        step();
        check("ar_nostale2", 512'(a_valid_o), 512'd0);
        check("ar_count2", 512'(a_count), 512'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha_multi_lane_pad_hash.md
SHA_MULTI_LANE_PAD_HASH -- requirements
Module: sha_multi_lane_pad_hash

Interface
REQ-001 Parameter LANES, default 1: number of independent hash lanes padded in lockstep (1..8).
REQ-002 Parameter DIGEST_WORDS, default 8: 32-bit digest words taken per lane (8 = SHA-256, 7 = SHA-224).
REQ-003 Parameter WRAPPED, default 1: 1 = wrapped pipeline layout, 0 = canonical FIPS 180-4 layout.
REQ-004 Port clk  input  1  sole clock; all state on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port state_i  input  LANES x 8 x 32  per-lane HashState words a..h (index 0 = a).
REQ-007 Port valid_i  input  1  state_i/newblock_i valid this cycle.
REQ-008 Port newblock_i  input  1  sideband tag carried with the beat.
REQ-009 Port ready_o  output  1  block accepts a beat this cycle.
REQ-010 Port padded_o  output  LANES x 16 x 32  per-lane padded 512-bit block, word 0 first.
REQ-011 Port valid_o  output  1  padded_o/newblock_o valid.
REQ-012 Port newblock_o  output  1  newblock_i of the presented beat.
REQ-013 Port ready_i  input  1  downstream accepts the presented beat.
REQ-014 Port count_o  output  16  number of output handshakes completed, wraps modulo 2^16.

Function
REQ-015 Input handshake: beat accepted when valid_i && ready_o; output handshake: valid_o && ready_i.
REQ-016 Storage: 2-entry skid buffer per beat (all lanes + newblock); FSM states EMPTY, ONE, TWO = entries held.
REQ-017 Transitions: accept-only -> count+1; output-only -> count-1; both or neither -> unchanged.
REQ-018 ready_o SHALL be registered: 1 in EMPTY and ONE, 0 in TWO; never combinationally depends on ready_i.
REQ-019 valid_o SHALL be 1 exactly in ONE and TWO; the oldest entry is always presented (FIFO order).
REQ-020 Latency: beat accepted in cycle N with buffer EMPTY appears on valid_o in cycle N+1.
REQ-021 Simultaneous accept and output in ONE: stays ONE, new beat presented in the next cycle with no bubble.
REQ-022 Simultaneous accept and output in TWO is impossible (ready_o = 0); output-only in TWO -> ONE, ready_o = 1 next cycle.
REQ-023 Presented padded_o/newblock_o SHALL hold stable while valid_o && !ready_i.
REQ-024 Length word L = DIGEST_WORDS*32 (256 or 224); padding marker M = 32'h80000000.
REQ-025 WRAPPED=1, per lane: word0 = a, word1 = L, words2..7 = 0, word8 = M, words9..15 = h,g,f,e,d,c,b.
REQ-026 WRAPPED=0, per lane: words 0..DIGEST_WORDS-1 = a.., word DIGEST_WORDS = M, following words = 0, word15 = L.
REQ-027 WRAPPED=1 with DIGEST_WORDS != 8 SHALL fail elaboration; LANES outside 1..8 SHALL fail elaboration.
REQ-028 With DIGEST_WORDS = 7, word h SHALL NOT affect padded_o.
REQ-029 Lanes are independent bit-for-bit; lane k output depends only on lane k input.
REQ-030 count_o increments by 1 on each output handshake; 16'hFFFF wraps to 0.

Reset
REQ-031 While rst = 1: FSM = EMPTY, valid_o = 0, ready_o = 1, count_o = 0, newblock_o = 0, padded_o = 0; inputs ignored.
REQ-032 Reset asserted mid-operation SHALL discard all buffered beats immediately (asynchronous), with no output handshake.
REQ-033 First accept possible on the first rising edge with rst = 0.

Verification
REQ-034 LANES=1, WRAPPED=1, a..h = 1..8, ready_i = 1 -> next cycle padded_o = {1,256,0,0,0,0,0,0,80000000,8,7,6,5,4,3,2}, count_o = 1.
REQ-035 WRAPPED=0, DIGEST_WORDS=7, a..g = 1..7, h = FFFFFFFF -> padded_o = {1..7,80000000,0 x7,224}.
REQ-036 ready_i = 0, three back-to-back beats B0,B1,B2 -> ready_o drops after B1, B2 held off; release ready_i -> B0,B1,B2 in order, no loss or duplication.
REQ-037 LANES=4, distinct random states, random valid_i/ready_i for 10k cycles -> scoreboard match per lane, count_o equals output handshakes mod 2^16.
REQ-038 Assert rst with buffer in TWO -> same cycle valid_o = 0, count_o = 0; after release, ready_o = 1 and no stale beat emerges.
